ddr_a2m_err_resp: RTL

Error responder for the AXI to MBA bridge. Requests that the request error check flags (unsupported AXSIZE of 32/64/128 bytes, or FIXED/reserved AXBURST) are steered here instead of to the MBA side. This block completes those transactions on the AXI side with SLVERR:
- Write: it sinks every W beat and returns one B response.
- Read: it returns AXLEN+1 R beats.

The AXI master always sees a protocol-correct completion, and no MBA traffic is generated.

---
 rtl/ddr_a2m_err_resp.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ddr_a2m_err_resp.sv
// ddr_a2m_err_resp
// Completes error-flagged AXI requests with SLVERR so the master always sees
// a protocol-correct ending. Writes are sunk until WLAST and answered with a
// single B. Reads return ARLEN+1 zero-data beats. The write and read sides are
// independent FSMs, and no MBA traffic is generated.
module ddr_a2m_err_resp #(
    parameter int P_IDW = 8,
    parameter int P_DW  = 128
) (
    input  logic             ACLK,
    input  logic             ARST,
    // write address
    input  logic             AWVALID,
    output logic             AWREADY,
    input  logic [P_IDW-1:0] AWID,
    input  logic [7:0]       AWLEN,
    // write data
    input  logic             WVALID,
    output logic             WREADY,
    input  logic             WLAST,
    // write response
    output logic             BVALID,
    input  logic             BREADY,
    output logic [P_IDW-1:0] BID,
    output logic [1:0]       BRESP,
    // read address
    input  logic             ARVALID,
    output logic             ARREADY,
    input  logic [P_IDW-1:0] ARID,
    input  logic [7:0]       ARLEN,
    // read data
    output logic             RVALID,
    input  logic             RREADY,
    output logic [P_IDW-1:0] RID,
    output logic [P_DW-1:0]  RDATA,
    output logic [1:0]       RRESP,
    output logic             RLAST
);

    localparam logic [1:0] C_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    wstate_t          r_wstate;
    wstate_t          w_wstate_nxt;
    logic [P_IDW-1:0] r_awid;
    logic             w_awid_load;
    logic             w_awready;
    logic             w_wready;
    logic             w_bvalid;

    // AWLEN is informational only: the burst is terminated by WLAST.
    logic             w_unused_awlen;
    assign w_unused_awlen = ^AWLEN;

    // Write FSM state register
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    // Capture the write ID on the AW handshake; it is returned on BID
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            r_awid <= '0;
        end else if (w_awid_load) begin
            r_awid <= AWID;
        end
    end

    // Write FSM next state and handshake decode from registered state
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awid_load  = 1'b0;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        unique case (r_wstate)
            W_IDLE: begin
                w_awready = 1'b1;
                if (AWVALID) begin
                    w_awid_load  = 1'b1;
                    w_wstate_nxt = W_DATA;
                end
            end
            W_DATA: begin
                w_wready = 1'b1;
                if (WVALID && WLAST) begin
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (BREADY) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: begin
                w_wstate_nxt = W_IDLE;
            end
        endcase
    end

    assign AWREADY = w_awready;
    assign WREADY  = w_wready;
    assign BVALID  = w_bvalid;
    assign BID     = r_awid;
    assign BRESP   = w_bvalid ? C_SLVERR : 2'b00;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rstate_t          r_rstate;
    rstate_t          w_rstate_nxt;
    logic [P_IDW-1:0] r_arid;
    logic [7:0]       r_beat_cnt;
    logic             w_ar_load;
    logic             w_beat_dec;
    logic             w_arready;
    logic             w_rvalid;
    logic             w_rlast;

    // Read FSM state register
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    // Read ID capture and remaining-beat counter; the counter stops at 0
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            r_arid     <= '0;
            r_beat_cnt <= '0;
        end else if (w_ar_load) begin
            r_arid     <= ARID;
            r_beat_cnt <= ARLEN;
        end else if (w_beat_dec) begin
            r_beat_cnt <= r_beat_cnt - 8'd1;
        end
    end

    // Read FSM next state, counter control and handshake decode
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_ar_load    = 1'b0;
        w_beat_dec   = 1'b0;
        w_arready    = 1'b0;
        w_rvalid     = 1'b0;
        w_rlast      = 1'b0;
        unique case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (ARVALID) begin
                    w_ar_load    = 1'b1;
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                w_rlast  = (r_beat_cnt == 8'd0);
                if (RREADY) begin
                    if (r_beat_cnt == 8'd0) begin
                        w_rstate_nxt = R_IDLE;
                    end else begin
                        w_beat_dec = 1'b1;
                    end
                end
            end
            default: begin
                w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    assign ARREADY = w_arready;
    assign RVALID  = w_rvalid;
    assign RLAST   = w_rlast;
    assign RID     = r_arid;
    assign RDATA   = '0;
    assign RRESP   = w_rvalid ? C_SLVERR : 2'b00;

endmodule
